// File: rtl/krypton_wb_arbiter.sv
// Writeback arbiter for the Krypton shader core.
// Per-unit result FIFOs feed one registered writeback stage through a
// round-robin grant. Also exports FIFO-full status and activity counters.
module krypton_wb_arbiter #(
  parameter int NUM_UNITS      = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int WARP_ID_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_UNITS-1:0]                unit_valid,
  output logic [NUM_UNITS-1:0]                unit_ready,
  output logic [NUM_UNITS-1:0]                unit_busy,
  input  logic [NUM_UNITS*WARP_ID_WIDTH-1:0]  unit_warp_id,
  input  logic [NUM_UNITS*REG_ADDR_WIDTH-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0]                unit_is_vector,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]     unit_data,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [WARP_ID_WIDTH-1:0]            wb_warp_id,
  output logic [REG_ADDR_WIDTH-1:0]           wb_rd,
  output logic                                wb_is_vector,
  output logic [DATA_WIDTH-1:0]               wb_data,
  output logic [2:0]                          wb_unit,
  output logic [31:0]                         wb_count,
  output logic [31:0]                         conflict_count,
  output logic [31:0]                         stall_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef struct packed {
    logic [WARP_ID_WIDTH-1:0]  warp;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      vec;
    logic [DATA_WIDTH-1:0]     data;
  } wb_ent_t;

  wb_ent_t              head [NUM_UNITS];
  logic [NUM_UNITS-1:0] nonempty;
  logic [NUM_UNITS-1:0] pop;

  logic          adv;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          multi_ne;

  wb_ent_t       wb_q, wb_d;
  logic          wb_valid_q, wb_valid_d;
  logic [2:0]    wb_unit_q, wb_unit_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [31:0]   wb_count_q, conflict_q, stall_q;

  // Per-unit FIFOs. Count is one bit wider than the pointers, so its MSB
  // alone marks "full" (count == FIFO_DEPTH).
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_fifo
    wb_ent_t       mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic          push;
    wb_ent_t       ent;

    assign unit_ready[g] = ~cnt_q[PW];
    assign unit_busy[g]  = cnt_q[PW];
    assign nonempty[g]   = (cnt_q != '0);
    assign head[g]       = mem_q[rptr_q];
    assign push          = unit_valid[g] & ~cnt_q[PW] & ~flush;
    assign ent.warp      = unit_warp_id[g*WARP_ID_WIDTH +: WARP_ID_WIDTH];
    assign ent.rd        = unit_rd[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign ent.vec       = unit_is_vector[g];
    assign ent.data      = unit_data[g*DATA_WIDTH +: DATA_WIDTH];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= ent;
    end

    // Pointer and occupancy update; flush empties the FIFO.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push)   wptr_q <= wptr_q + 1'b1;
        if (pop[g]) rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop[g]};
      end
    end
  end

  // Round-robin search starting at rr_q, wrapping modulo NUM_UNITS.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      automatic int idx = int'(rr_q) + off;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  assign adv      = !wb_valid_q || wb_ready;
  assign multi_ne = ($countones(nonempty) >= 2);

  // Pop only the granted FIFO, and only when the stage actually advances.
  always_comb begin
    pop = '0;
    if (adv && gnt_vld && !flush) pop[gnt_idx] = 1'b1;
  end

  // Output stage next state: load granted head, clear when idle, hold on stall.
  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    wb_unit_d  = wb_unit_q;
    rr_d       = rr_q;
    if (flush) begin
      wb_valid_d = 1'b0;
      rr_d       = '0;
    end else if (adv) begin
      if (gnt_vld) begin
        wb_d       = head[gnt_idx];
        wb_valid_d = 1'b1;
        wb_unit_d  = 3'(gnt_idx);
        rr_d       = (gnt_idx == IW'(NUM_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        wb_valid_d = 1'b0;
      end
    end
  end

  // Output stage and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_unit_q  <= '0;
      rr_q       <= '0;
    end else begin
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      wb_unit_q  <= wb_unit_d;
      rr_q       <= rr_d;
    end
  end

  // Activity counters; flush discards the handshake and the grant but
  // leaves accumulated counts intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count_q <= '0;
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (wb_valid_q && wb_ready && !flush) wb_count_q <= wb_count_q + 32'd1;
      if (adv && multi_ne && !flush)        conflict_q <= conflict_q + 32'd1;
      if (wb_valid_q && !wb_ready)          stall_q    <= stall_q + 32'd1;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_warp_id     = wb_q.warp;
  assign wb_rd          = wb_q.rd;
  assign wb_is_vector   = wb_q.vec;
  assign wb_data        = wb_q.data;
  assign wb_unit        = wb_unit_q;
  assign wb_count       = wb_count_q;
  assign conflict_count = conflict_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_krypton_wb_arbiter.sv
// Directed bench for krypton_wb_arbiter: reset, latency, round-robin,
// backpressure/full, rr wrap and flush, with hand-computed expectations.
module tb_krypton_wb_arbiter;
  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst, flush, wb_ready;
  logic [N-1:0]  unit_valid, unit_ready, unit_busy, unit_is_vector;
  logic [N*5-1:0]  unit_warp_id;
  logic [N*8-1:0]  unit_rd;
  logic [N*32-1:0] unit_data;
  logic          wb_valid, wb_is_vector;
  logic [4:0]    wb_warp_id;
  logic [7:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [2:0]    wb_unit;
  logic [31:0]   wb_count, conflict_count, stall_count;

  int total  = 0;
  int passed = 0;

  krypton_wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_busy(unit_busy),
    .unit_warp_id(unit_warp_id), .unit_rd(unit_rd),
    .unit_is_vector(unit_is_vector), .unit_data(unit_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp_id(wb_warp_id),
    .wb_rd(wb_rd), .wb_is_vector(wb_is_vector), .wb_data(wb_data),
    .wb_unit(wb_unit), .wb_count(wb_count),
    .conflict_count(conflict_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic offer(input int u, input logic [4:0] w, input logic [7:0] rd,
                       input logic v, input logic [31:0] d);
    unit_valid[u]          = 1'b1;
    unit_warp_id[u*5 +: 5] = w;
    unit_rd[u*8 +: 8]      = rd;
    unit_is_vector[u]      = v;
    unit_data[u*32 +: 32]  = d;
  endtask

  initial begin
    logic [2:0]  exp_u [5];
    logic [31:0] exp_d [5];
    exp_u = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd0};
    exp_d = '{32'hA0, 32'h41, 32'hA1, 32'h42, 32'hA2};

    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    unit_valid = '0; unit_is_vector = '0;
    unit_warp_id = '0; unit_rd = '0; unit_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", wb_valid, 0);
    chk("rst_ready", unit_ready, 5'b11111);
    chk("rst_busy", unit_busy, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_unit", wb_unit, 0);
    chk("rst_cnts", {wb_count, conflict_count}, 0);
    chk("rst_stall", stall_count, 0);
    tick();
    chk("idle_valid", wb_valid, 0);

    // Single ALU push: two-cycle latency
    offer(0, 5'd3, 8'h12, 1'b1, 32'hDEADBEEF);
    tick();
    unit_valid = '0;
    chk("lat_t1_valid", wb_valid, 0);
    tick();
    chk("lat_valid", wb_valid, 1);
    chk("lat_warp", wb_warp_id, 3);
    chk("lat_rd", wb_rd, 8'h12);
    chk("lat_vec", wb_is_vector, 1);
    chk("lat_data", wb_data, 32'hDEADBEEF);
    chk("lat_unit", wb_unit, 0);
    tick();
    chk("lat_count", wb_count, 1);
    chk("lat_idle", wb_valid, 0);

    // FPU, SFU, LSU at once: grants 1,2,3
    offer(1, 5'd1, 8'h01, 1'b0, 32'h11);
    offer(2, 5'd2, 8'h02, 1'b0, 32'h22);
    offer(3, 5'd3, 8'h03, 1'b0, 32'h33);
    tick();
    unit_valid = '0;
    tick(); chk("rr_g0", wb_unit, 1); chk("rr_d0", wb_data, 32'h11);
    tick(); chk("rr_g1", wb_unit, 2); chk("rr_d1", wb_data, 32'h22);
    tick(); chk("rr_g2", wb_unit, 3); chk("rr_d2", wb_data, 32'h33);
    tick();
    chk("rr_idle", wb_valid, 0);
    chk("rr_conflict", conflict_count, 2);
    chk("rr_count", wb_count, 4);

    // FPU fill under backpressure: stage takes e0, FIFO holds e1..e4, e5 refused
    wb_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      offer(1, 5'd7, 8'h20 + 8'(j), 1'b0, 32'hF000_0000 + j);
      tick();
      chk("full_ready", unit_ready[1], (j < 4) ? 1 : 0);
      chk("full_busy", unit_busy[1], (j < 4) ? 0 : 1);
    end
    unit_valid = '0;
    chk("full_hold_valid", wb_valid, 1);
    chk("full_hold_data", wb_data, 32'hF000_0000);
    chk("full_stall", stall_count, 4);
    wb_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("drain_data", wb_data, 32'hF000_0000 + j);
      chk("drain_rd", wb_rd, 8'h20 + 8'(j));
      chk("drain_unit", wb_unit, 1);
      if (j == 1) chk("drain_ready", unit_ready[1], 1);
    end
    tick();
    chk("drain_idle", wb_valid, 0);
    chk("drain_count", wb_count, 9);
    chk("drain_stall", stall_count, 4);

    // ALU and TMU both busy: alternate grants, rr wraps 4 -> 0
    wb_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      offer(0, 5'd0, 8'h00, 1'b0, 32'hA0 + j);
      offer(4, 5'd4, 8'h04, 1'b1, 32'h40 + j);
      tick();
      if (j == 1) begin
        chk("alt_first_unit", wb_unit, 4);
        chk("alt_first_data", wb_data, 32'h40);
      end
    end
    unit_valid = '0;
    chk("alt_stall", stall_count, 5);
    wb_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("alt_unit", wb_unit, exp_u[j]);
      chk("alt_data", wb_data, exp_d[j]);
    end
    tick();
    chk("alt_idle", wb_valid, 0);
    chk("alt_count", wb_count, 15);
    chk("alt_conflict", conflict_count, 7);

    // Flush with queued entries and a simultaneous push
    wb_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      offer(2, 5'd9, 8'h30, 1'b0, 32'hC0 + j);
      tick();
    end
    unit_valid = '0;
    chk("fl_pre_valid", wb_valid, 1);
    chk("fl_pre_data", wb_data, 32'hC0);
    flush = 1'b1;
    wb_ready = 1'b1;
    offer(3, 5'd1, 8'h77, 1'b0, 32'hBAD);
    tick();
    flush = 1'b0;
    unit_valid = '0;
    chk("fl_valid", wb_valid, 0);
    chk("fl_count", wb_count, 15);
    chk("fl_stall", stall_count, 7);
    chk("fl_ready", unit_ready, 5'b11111);
    tick(); tick();
    chk("fl_empty", wb_valid, 0);
    chk("fl_count2", wb_count, 15);

    // rr_ptr back at 0 after flush: FPU wins over LSU
    offer(1, 5'd1, 8'h51, 1'b0, 32'h51);
    offer(3, 5'd3, 8'h53, 1'b0, 32'h53);
    tick();
    unit_valid = '0;
    tick(); chk("post_fl_g0", wb_unit, 1);
    tick(); chk("post_fl_g1", wb_unit, 3);
    tick();
    chk("post_fl_idle", wb_valid, 0);
    chk("post_fl_count", wb_count, 17);
    chk("post_fl_conflict", conflict_count, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
